// File: rtl/seq_checker.sv
// ----------------------------------------------------------------------------
// seq_checker
// Receive-side checker for the 16-bit load/increment sequence generator.
// It verifies that each valid sample equals the previous sample + 1 (mod
// 2^WIDTH). A sample flagged with resync is taken as a new base. The block
// reports lock status, registered per-sample mismatch pulses and a saturating
// error count.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset; clears all state immediately
//   valid      din carries a sample this cycle
//   resync     din is a legitimate reload (only meaningful with valid)
//   din        sampled stream value
//   clear_err  synchronous clear of err_count (wins over an increment)
//   locked     1 while in LOCKED
//   mismatch   one-cycle registered pulse for each counted error
//   err_count  saturating count of mismatches seen while LOCKED
//   expected   next value the checker expects
// ----------------------------------------------------------------------------
module seq_checker #(
   parameter int WIDTH    = 16,
   parameter int LOCK_LEN = 4,
   parameter int LOSS_LEN = 3,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid,
   input  logic             resync,
   input  logic [WIDTH-1:0] din,
   input  logic             clear_err,
   output logic             locked,
   output logic             mismatch,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] expected
);

   // One-hot style encoding leaves spare codes, which the next-state logic
   // steers back to SEARCH.
   typedef enum logic [1:0] {
      SEARCH = 2'b01,
      LOCKED = 2'b10
   } state_t;

   localparam logic [7:0]       LOCK_TGT = 8'(LOCK_LEN);
   localparam logic [7:0]       LOSS_TGT = 8'(LOSS_LEN);
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   state_t           state;
   state_t           next_state;
   logic [7:0]       run_cnt;
   logic [7:0]       next_run;
   logic [7:0]       miss_cnt;
   logic [7:0]       next_miss;
   logic             primed;
   logic             next_primed;
   logic [WIDTH-1:0] next_expected;
   logic [WIDTH-1:0] din_plus;
   logic             match;
   logic             hit;

   // Wrap from all-ones to zero is a legal step, so plain truncation suffices.
   assign din_plus = din + WIDTH'(1);
   assign match    = (din == expected);

   // State and datapath registers. 'primed' records that a base value has
   // been seen since reset, so the very first sample is never compared.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= SEARCH;
         run_cnt   <= '0;
         miss_cnt  <= '0;
         primed    <= 1'b0;
         expected  <= '0;
         mismatch  <= 1'b0;
         err_count <= '0;
      end else begin
         state    <= next_state;
         run_cnt  <= next_run;
         miss_cnt <= next_miss;
         primed   <= next_primed;
         expected <= next_expected;
         mismatch <= hit;
         if (clear_err) begin
            err_count <= '0;
         end else if (hit && (err_count != ERR_MAX)) begin
            err_count <= err_count + ERR_W'(1);
         end
      end
   end

   // Next-state and counter logic. Every valid sample re-anchors expected on
   // the received value, whether or not it matched.
   always_comb begin
      next_state    = state;
      next_run      = run_cnt;
      next_miss     = miss_cnt;
      next_primed   = primed;
      next_expected = expected;
      hit           = 1'b0;

      if (valid) begin
         next_expected = din_plus;
         next_primed   = 1'b1;
      end

      case (state)
         SEARCH: begin
            if (valid) begin
               if (resync || !primed) begin
                  next_run = '0;
               end else if (match) begin
                  if ((run_cnt + 8'd1) == LOCK_TGT) begin
                     next_state = LOCKED;
                     next_run   = '0;
                     next_miss  = '0;
                  end else begin
                     next_run = run_cnt + 8'd1;
                  end
               end else begin
                  next_run = '0;
               end
            end
         end
         LOCKED: begin
            if (valid) begin
               if (resync || match) begin
                  next_miss = '0;
               end else begin
                  hit = 1'b1;
                  if ((miss_cnt + 8'd1) == LOSS_TGT) begin
                     next_state = SEARCH;
                     next_run   = '0;
                     next_miss  = '0;
                  end else begin
                     next_miss = miss_cnt + 8'd1;
                  end
               end
            end
         end
         default: begin
            next_state = SEARCH;
            next_run   = '0;
            next_miss  = '0;
         end
      endcase
   end

   // Output decode from the registered state.
   always_comb begin
      locked = (state == LOCKED);
   end

endmodule

// File: tb/tb_seq_checker.sv
// ----------------------------------------------------------------------------
// tb_seq_checker
// Directed testbench for seq_checker: lock acquisition, wrap-around, resync
// loads, mismatch counting, loss of lock, saturation, clear_err and
// asynchronous reset. Expected values are hand-computed constants or a small
// running model of the next expected stream value.
// ----------------------------------------------------------------------------
module tb_seq_checker;

   logic        clk;
   logic        reset;
   logic        valid;
   logic        resync;
   logic [15:0] din;
   logic        clear_err;
   logic        locked;
   logic        mismatch;
   logic [7:0]  err_count;
   logic [15:0] expected;

   int errors;
   int checks;
   logic [15:0] cur_exp;
   logic [15:0] d;

   seq_checker #(
      .WIDTH   (16),
      .LOCK_LEN(4),
      .LOSS_LEN(3),
      .ERR_W   (8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .valid    (valid),
      .resync   (resync),
      .din      (din),
      .clear_err(clear_err),
      .locked   (locked),
      .mismatch (mismatch),
      .err_count(err_count),
      .expected (expected)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a stalled run.
   initial begin
      #500000;
      $display("[TB] FAIL timeout: got no_finish expected finish");
      $fatal(1, "[TB] timeout");
   end

   // Compare one observed value against its required value.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, required);
      end
   endtask

   // Present one sample for exactly one rising edge, then return 1 ns after
   // that edge with the inputs idle so outputs can be checked.
   task automatic applyStimulus(input logic v, input logic rs,
                                input logic [15:0] value, input logic clr);
      @(negedge clk);
      valid     = v;
      resync    = rs;
      din       = value;
      clear_err = clr;
      @(posedge clk);
      #1;
      valid     = 1'b0;
      resync    = 1'b0;
      clear_err = 1'b0;
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      valid     = 1'b0;
      resync    = 1'b0;
      din       = '0;
      clear_err = 1'b0;
      reset     = 1'b1;

      // Asynchronous reset before any clock edge.
      #2 reset = 1'b0;
      #1;
      checkOutput("rst_locked", 32'(locked), 32'd0);
      checkOutput("rst_mismatch", 32'(mismatch), 32'd0);
      checkOutput("rst_err", 32'(err_count), 32'd0);
      checkOutput("rst_expected", 32'(expected), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Acquire lock: base 0x10 plus four correct steps.
      applyStimulus(1'b1, 1'b0, 16'h0010, 1'b0);
      checkOutput("first_expected", 32'(expected), 32'h0011);
      checkOutput("first_locked", 32'(locked), 32'd0);
      applyStimulus(1'b1, 1'b0, 16'h0011, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0012, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0013, 1'b0);
      checkOutput("three_locked", 32'(locked), 32'd0);
      applyStimulus(1'b1, 1'b0, 16'h0014, 1'b0);
      checkOutput("lock_locked", 32'(locked), 32'd1);
      checkOutput("lock_expected", 32'(expected), 32'h0015);
      checkOutput("lock_err", 32'(err_count), 32'd0);

      // Resync near the top, then wrap through zero.
      applyStimulus(1'b1, 1'b1, 16'hFFFE, 1'b0);
      checkOutput("resync_mismatch", 32'(mismatch), 32'd0);
      applyStimulus(1'b1, 1'b0, 16'hFFFF, 1'b0);
      checkOutput("ffff_expected", 32'(expected), 32'h0000);
      applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
      checkOutput("wrap_mismatch", 32'(mismatch), 32'd0);
      checkOutput("wrap_expected", 32'(expected), 32'h0001);
      checkOutput("wrap_locked", 32'(locked), 32'd1);

      // Single mismatch with re-anchor, then recovery.
      applyStimulus(1'b1, 1'b1, 16'h001F, 1'b0);
      checkOutput("exp_0020", 32'(expected), 32'h0020);
      applyStimulus(1'b1, 1'b0, 16'h0050, 1'b0);
      checkOutput("single_mismatch", 32'(mismatch), 32'd1);
      checkOutput("single_err", 32'(err_count), 32'd1);
      checkOutput("single_expected", 32'(expected), 32'h0051);
      applyStimulus(1'b1, 1'b0, 16'h0051, 1'b0);
      checkOutput("recover_mismatch", 32'(mismatch), 32'd0);
      checkOutput("recover_err", 32'(err_count), 32'd1);

      // Three consecutive mismatches drop lock on the third.
      applyStimulus(1'b1, 1'b0, 16'h0100, 1'b0);
      checkOutput("miss1_locked", 32'(locked), 32'd1);
      applyStimulus(1'b1, 1'b0, 16'h0200, 1'b0);
      checkOutput("miss2_locked", 32'(locked), 32'd1);
      checkOutput("miss2_err", 32'(err_count), 32'd3);
      applyStimulus(1'b1, 1'b0, 16'h0300, 1'b0);
      checkOutput("miss3_mismatch", 32'(mismatch), 32'd1);
      checkOutput("miss3_locked", 32'(locked), 32'd0);
      checkOutput("miss3_err", 32'(err_count), 32'd4);
      applyStimulus(1'b1, 1'b0, 16'h0400, 1'b0);
      checkOutput("search_mismatch", 32'(mismatch), 32'd0);
      checkOutput("search_err", 32'(err_count), 32'd4);
      checkOutput("search_expected", 32'(expected), 32'h0401);

      // Re-lock from the anchored value, then a resync load while locked.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 16'h0401 + 16'(i), 1'b0);
      end
      checkOutput("relock_locked", 32'(locked), 32'd1);
      applyStimulus(1'b1, 1'b1, 16'h0006, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'h0007, 1'b0);
      applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0);
      checkOutput("load_mismatch", 32'(mismatch), 32'd0);
      checkOutput("load_expected", 32'(expected), 32'h1235);
      checkOutput("load_err", 32'(err_count), 32'd4);

      // Idle cycles with changing din must leave everything alone.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b0, 16'hDEAD + 16'(i), 1'b0);
      end
      checkOutput("idle_expected", 32'(expected), 32'h1235);
      checkOutput("idle_locked", 32'(locked), 32'd1);
      checkOutput("idle_err", 32'(err_count), 32'd4);
      checkOutput("idle_mismatch", 32'(mismatch), 32'd0);

      // Saturation: 3 mismatches then 4 good samples per round.
      cur_exp = 16'h1235;
      for (int r = 0; r < 87; r++) begin
         for (int k = 0; k < 3; k++) begin
            d = cur_exp + 16'd5;
            applyStimulus(1'b1, 1'b0, d, 1'b0);
            cur_exp = d + 16'd1;
         end
         for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, cur_exp, 1'b0);
            cur_exp = cur_exp + 16'd1;
         end
      end
      checkOutput("sat_err", 32'(err_count), 32'h00FF);
      checkOutput("sat_locked", 32'(locked), 32'd1);
      checkOutput("sat_expected", 32'(expected), 32'(cur_exp));

      // clear_err wins over a coincident mismatch, pulse still fires.
      d = cur_exp + 16'd9;
      applyStimulus(1'b1, 1'b0, d, 1'b1);
      cur_exp = d + 16'd1;
      checkOutput("clr_mismatch", 32'(mismatch), 32'd1);
      checkOutput("clr_err", 32'(err_count), 32'd0);
      d = cur_exp + 16'd9;
      applyStimulus(1'b1, 1'b0, d, 1'b0);
      checkOutput("post_clr_err", 32'(err_count), 32'd1);
      checkOutput("post_clr_locked", 32'(locked), 32'd1);

      // Asynchronous reset mid-cycle.
      #2 reset = 1'b0;
      #1;
      checkOutput("async_locked", 32'(locked), 32'd0);
      checkOutput("async_mismatch", 32'(mismatch), 32'd0);
      checkOutput("async_err", 32'(err_count), 32'd0);
      checkOutput("async_expected", 32'(expected), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // After reset the next sample is a fresh base.
      applyStimulus(1'b1, 1'b0, 16'h7777, 1'b0);
      checkOutput("rebase_mismatch", 32'(mismatch), 32'd0);
      checkOutput("rebase_expected", 32'(expected), 32'h7778);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 16'h7778 + 16'(i), 1'b0);
      end
      checkOutput("rebase_locked", 32'(locked), 32'd1);
      checkOutput("rebase_err", 32'(err_count), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_checker.md
Name: seq_checker

Overview:
- Receive-side companion to the team's 16-bit load/increment sequence generator.
- Samples the generator's 16-bit output stream and verifies that each valid sample equals the previous sample + 1 (mod 2^16).
- The generator can legitimately reload an arbitrary value; the checker treats a sample flagged by `resync` as a new base, not an error.
- Reports lock status, per-sample mismatch pulses and a saturating error count; sits on the consumer side of the generator's `out` bus.

Parameters:
- WIDTH, 16: data width of the checked stream.
- LOCK_LEN, 4: consecutive correct samples needed to go SEARCH -> LOCKED (1..255).
- LOSS_LEN, 3: consecutive mismatches needed to go LOCKED -> SEARCH (1..255).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset (asserts on 0, all state cleared immediately).
- valid  input  1  din carries a sample this cycle.
- resync  input  1  qualifies din as a legitimate reload (generator load path); only meaningful with valid.
- din  input  WIDTH  sampled stream value.
- clear_err  input  1  synchronous clear of err_count.
- locked  output  1  1 while in LOCKED.
- mismatch  output  1  one-cycle pulse, registered, for a counted error.
- err_count  output  ERR_W  saturating count of mismatches seen while LOCKED.
- expected  output  WIDTH  next value the checker expects.

Behaviour:
- Reset (reset=0, async):
  - state=SEARCH; locked=0, mismatch=0, err_count=0, expected=0.
  - Internal run/miss counters = 0.
  - Outputs are registered, so the reset values appear without a clock edge.
- Cycles with valid=0: no state, counter or expected change; mismatch=0.
- Arithmetic: expected is always updated to din+1 truncated to WIDTH bits. 0xFFFF -> 0x0000 is a correct step, never an error.
- "Match" means din == expected.
- SEARCH, on a valid sample:
  - resync=1, or the first valid sample after reset: expected<=din+1, run_cnt<=0, no error.
  - Match: run_cnt++; when run_cnt reaches LOCK_LEN, go to LOCKED and clear run_cnt.
  - No match: run_cnt<=0.
  - expected<=din+1 in all cases.
  - mismatch never pulses and err_count never changes in SEARCH.
- LOCKED, on a valid sample:
  - resync=1: expected<=din+1, miss_cnt<=0, no error, stay LOCKED.
  - Match: miss_cnt<=0.
  - No match: mismatch=1 on the following cycle; err_count++ saturating at 2^ERR_W-1; miss_cnt++; expected<=din+1 (re-anchor on the received value).
  - When miss_cnt reaches LOSS_LEN: go to SEARCH, run_cnt<=0, miss_cnt<=0.
- Latency:
  - locked, mismatch and expected all update on the clock edge that samples din.
  - They are visible one cycle after the sample.
- clear_err:
  - Sets err_count to 0 next edge.
  - If a mismatch occurs in the same cycle, clear wins (err_count=0), but the mismatch pulse still fires.
- Reset mid-stream: all state is lost; the next valid sample is treated as the first sample.
- An unknown/illegal state encoding recovers to SEARCH.

Test Plan:
- Reset, then valid samples 0x0010,0x0011,0x0012,0x0013,0x0014 (LOCK_LEN=4) -> locked=1 one cycle after 0x0014; err_count=0; expected=0x0015.
- While locked, feed 0xFFFE,0xFFFF,0x0000 with resync=1 on 0xFFFE only -> no mismatch; expected=0x0001; locked stays 1.
- While locked, expected=0x0020, feed 0x0050 -> mismatch pulses 1 cycle; err_count=1; expected=0x0051; then 0x0051 -> no error, miss_cnt cleared.
- Three consecutive mismatches while locked (LOSS_LEN=3) -> err_count +3; locked drops to 0 after the third; further bad samples leave err_count unchanged.
- Load behaviour: locked, valid+resync with din=0x1234 after 0x0007 -> no mismatch; expected=0x1235. Also hold valid=0 for 10 cycles -> all outputs constant.
- Saturation, clear and reset:
  - Force 260 mismatches (periodically re-locking) -> err_count holds 0xFF.
  - clear_err coinciding with a mismatch -> err_count=0, mismatch=1.
  - Assert reset asynchronously mid-cycle -> all outputs 0 immediately.
